// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int          FETCH_INSTR_W  = 32;
    localparam int          FETCH_ADDR_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instruction;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries; head, count and
// full/empty are all registered so decode sees no combinational path from push.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output logic [DATA_W-1:0]            head_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              full_q, empty_q;

    // Next head: the slot after a pop, forwarded from data_i when that slot is written now.
    always_comb begin
        rd_d    = rd_q + PTR_W'(pop_i);
        wr_d    = wr_q + PTR_W'(push_i);
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (count_d == '0) begin
            head_d = head_q;
        end else if (push_i && (rd_d == wr_q)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_d];
        end
        if (clear_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            head_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, credits imem requests against FIFO space and drops
// stale responses after a redirect. Optional macro FETCH_QUEUE_BYPASS_EN adds an empty-FIFO bypass.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                       INSTRUCTION_WIDTH = FETCH_INSTR_W,
    parameter int                       ADDRESS_WIDTH     = FETCH_ADDR_W,
    parameter int                       QUEUE_DEPTH       = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = ADDRESS_WIDTH'(FETCH_RESET_PC),
    parameter logic [ADDRESS_WIDTH-1:0] PC_STEP           = ADDRESS_WIDTH'(FETCH_PC_STEP)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [ADDRESS_WIDTH-1:0]     imem_address,
    input  logic                         imem_ready,
    input  logic                         imem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
    input  logic                         branch_en,
    input  logic [ADDRESS_WIDTH-1:0]     branch_target,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [INSTRUCTION_WIDTH-1:0] id_instruction,
    output logic [ADDRESS_WIDTH-1:0]     id_pc
);

    localparam int             PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam int             ENTRY_W = INSTRUCTION_WIDTH + ADDRESS_WIDTH;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(QUEUE_DEPTH);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]         outstanding_q, outstanding_d;
    logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W:0]     credit_used;
    logic               accept, resp_live, bypass_vld, bypass_take, push, pop;

    // Every queued entry or in-flight request holds one FIFO slot, so a push can never overflow.
    assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req     = !rst && (state_q == FETCH) && !branch_en && !fifo_full
                          && (credit_used < DEPTH_C);
    assign imem_address = fetch_pc_q;
    assign accept       = imem_req && imem_ready;
    assign resp_live    = imem_rvalid && (state_q == FETCH) && !branch_en;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_vld = !rst && fifo_empty && resp_live;
`else
    assign bypass_vld = 1'b0;
`endif

    assign bypass_take    = bypass_vld && id_ready;
    assign push           = resp_live && !bypass_take;
    assign pop            = id_ready && !fifo_empty;
    assign id_valid       = !fifo_empty || bypass_vld;
    assign id_instruction = bypass_vld ? imem_instruction
                                       : fifo_head[ENTRY_W-1 -: INSTRUCTION_WIDTH];
    assign id_pc          = bypass_vld ? resp_pc_q : fifo_head[ADDRESS_WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (resp_live) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        // A response arriving with the redirect is itself stale and already retired here.
        if (branch_en) begin
            fetch_pc_d = branch_target;
            resp_pc_d  = branch_target;
            drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid);
            state_d    = (drop_cnt_d == '0) ? FETCH : DRAIN;
        end else if (state_q == DRAIN) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(imem_rvalid);
            if (drop_cnt_d == '0) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({imem_instruction, resp_pc_q}),
        .pop_i   (pop),
        .clear_i (branch_en),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming table, backpressure, redirect corner cases, PC wrap.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req, w_req;
    logic [31:0] imem_address, w_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_instruction;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        id_valid, w_valid;
    logic [31:0] id_instruction, w_instr;
    logic [31:0] id_pc, w_pc;

    int n_chk = 0;
    int n_err = 0;
    int ec    = 0;
    int lat   = 1;

    fetch_queue dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_address(imem_address), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_instruction(imem_instruction),
        .branch_en(branch_en), .branch_target(branch_target),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instruction(id_instruction), .id_pc(id_pc)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_address(w_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_instruction(imem_instruction),
        .branch_en(branch_en), .branch_target(branch_target),
        .id_ready(id_ready), .id_valid(w_valid),
        .id_instruction(w_instr), .id_pc(w_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // In-order instruction memory with a fixed response latency of lat cycles.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (imem_rvalid && mq.size() > 0) mq.delete(0);
            if (imem_req && imem_ready) mq.push_back('{imem_address, ec + lat});
        end
        ec++;
    end

    always @(negedge clk) begin
        if (mq.size() > 0 && mq[0].due <= ec) begin
            imem_rvalid      = 1'b1;
            imem_instruction = memf(mq[0].addr);
        end else begin
            imem_rvalid      = 1'b0;
            imem_instruction = 32'h0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic br, input logic [31:0] tgt);
        id_ready      = rdy;
        branch_en     = br;
        branch_target = tgt;
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic do_reset(input int l, input string tag);
        rst       = 1'b1;
        branch_en = 1'b0;
        id_ready  = 1'b0;
        lat       = l;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk({tag, "_req"},   imem_req, 32'h0);
        chk({tag, "_addr"},  imem_address, 32'h0);
        chk({tag, "_vld"},   id_valid, 32'h0);
        chk({tag, "_instr"}, id_instruction, 32'h0);
        chk({tag, "_pc"},    id_pc, 32'h0);
        chk({tag, "_waddr"}, w_addr, 32'hFFFF_FFF8);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] waddr;
        logic [31:0] wpc;
    } svec_t;

    svec_t       st [8];
    logic [31:0] bp_pc [5];
    int          nreq;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_instruction = 32'h0;
        branch_en = 1'b0; branch_target = 32'h0; id_ready = 1'b0;

`ifdef FETCH_QUEUE_BYPASS_EN
        st[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'hFFFF_FFF8, 32'h0};
        st[1] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
        st[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 32'h0000_0000, 32'hFFFF_FFFC};
        st[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h0000_0004, 32'h0};
        st[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h0000_0008, 32'h4};
        st[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'h0000_000C, 32'h8};
        st[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14, 32'h0000_0010, 32'hC};
        st[7] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h0000_0014, 32'hC};
`else
        st[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'hFFFF_FFF8, 32'h0};
        st[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'hFFFF_FFFC, 32'h0};
        st[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h0000_0000, 32'hFFFF_FFF8};
        st[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h0000_0004, 32'hFFFF_FFFC};
        st[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h0000_0008, 32'h0};
        st[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h0000_000C, 32'h4};
        st[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h0000_0010, 32'h8};
        st[7] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h0000_0014, 32'h8};
`endif
        bp_pc[0] = 32'h00; bp_pc[1] = 32'h04; bp_pc[2] = 32'h08;
        bp_pc[3] = 32'h0C; bp_pc[4] = 32'h10;

        // Streaming at latency 1, then a short stall; second instance checks PC wrap.
        do_reset(1, "rst0");
        for (int k = 0; k < 8; k++) begin
            drive(st[k].rdy, 1'b0, 32'h0);
            chk($sformatf("st%0d_req", k),   imem_req, 32'(st[k].req));
            chk($sformatf("st%0d_addr", k),  imem_address, st[k].addr);
            chk($sformatf("st%0d_vld", k),   id_valid, 32'(st[k].vld));
            chk($sformatf("st%0d_wreq", k),  w_req, 32'(st[k].req));
            chk($sformatf("st%0d_waddr", k), w_addr, st[k].waddr);
            chk($sformatf("st%0d_wvld", k),  w_valid, 32'(st[k].vld));
            if (st[k].vld) begin
                chk($sformatf("st%0d_pc", k),     id_pc, st[k].pc);
                chk($sformatf("st%0d_instr", k),  id_instruction, memf(st[k].pc));
                chk($sformatf("st%0d_wpc", k),    w_pc, st[k].wpc);
                chk($sformatf("st%0d_winstr", k), w_instr, memf(st[k].pc));
            end
            adv();
        end

        // Backpressure: credits cap requests at QUEUE_DEPTH, then drain in order.
        do_reset(1, "rst1");
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (imem_req) nreq++;
            if (k == 9) begin
                chk("bp_stall_req", imem_req, 32'h0);
                chk("bp_stall_vld", id_valid, 32'h1);
                chk("bp_stall_pc",  id_pc, 32'h0);
            end
            adv();
        end
        chk("bp_nreq", nreq, 32'd4);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            chk($sformatf("bp%0d_vld", k),   id_valid, 32'h1);
            chk($sformatf("bp%0d_pc", k),    id_pc, bp_pc[k]);
            chk($sformatf("bp%0d_instr", k), id_instruction, memf(bp_pc[k]));
            if (k == 0) chk("bp_rel_req0", imem_req, 32'h0);
            if (k == 1) begin
                chk("bp_rel_req1",  imem_req, 32'h1);
                chk("bp_rel_addr1", imem_address, 32'h10);
            end
            adv();
        end

        // Redirect with two requests in flight at latency 3.
        do_reset(3, "rst2");
        drive(1'b1, 1'b0, 32'h0);   chk("ra_c0_addr", imem_address, 32'h0); adv();
        drive(1'b1, 1'b0, 32'h0);   chk("ra_c1_addr", imem_address, 32'h4); adv();
        drive(1'b1, 1'b1, 32'h100); chk("ra_c2_req", imem_req, 32'h0);      adv();
        for (int k = 3; k < 10; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            if (k < 5) chk($sformatf("ra_c%0d_req", k), imem_req, 32'h0);
            if (k == 5) begin
                chk("ra_c5_req",  imem_req, 32'h1);
                chk("ra_c5_addr", imem_address, 32'h100);
            end
            if (k == 9 - BYP) begin
                chk("ra_first_vld",   id_valid, 32'h1);
                chk("ra_first_pc",    id_pc, 32'h100);
                chk("ra_first_instr", id_instruction, memf(32'h100));
            end else if (k < 9 - BYP) begin
                chk($sformatf("ra_c%0d_vld", k), id_valid, 32'h0);
            end
            adv();
        end

        // Redirect coinciding with a stale response and a completing pop.
        do_reset(2, "rst3");
        drive(1'b0, 1'b0, 32'h0);   chk("rb_c0_addr", imem_address, 32'h0); adv();
        drive(1'b0, 1'b0, 32'h0);   chk("rb_c1_addr", imem_address, 32'h4); adv();
        drive(1'b0, 1'b0, 32'h0);   chk("rb_c2_addr", imem_address, 32'h8); adv();
        drive(1'b1, 1'b1, 32'h300);
        chk("rb_c3_vld",   id_valid, 32'h1);
        chk("rb_c3_pc",    id_pc, 32'h0);
        chk("rb_c3_instr", id_instruction, memf(32'h0));
        chk("rb_c3_req",   imem_req, 32'h0);
        adv();
        for (int k = 4; k < 9; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            if (k == 4) chk("rb_c4_req", imem_req, 32'h0);
            if (k == 5) begin
                chk("rb_c5_req",  imem_req, 32'h1);
                chk("rb_c5_addr", imem_address, 32'h300);
            end
            if (k == 8 - BYP) begin
                chk("rb_first_vld",   id_valid, 32'h1);
                chk("rb_first_pc",    id_pc, 32'h300);
                chk("rb_first_instr", id_instruction, memf(32'h300));
            end else if (k < 8 - BYP) begin
                chk($sformatf("rb_c%0d_vld", k), id_valid, 32'h0);
            end
            adv();
        end

        // Second redirect while draining: the later target wins.
        do_reset(3, "rst4");
        drive(1'b1, 1'b0, 32'h0);   adv();
        drive(1'b1, 1'b0, 32'h0);   adv();
        drive(1'b1, 1'b1, 32'h100); chk("rc_c2_req", imem_req, 32'h0); adv();
        drive(1'b1, 1'b1, 32'h200);
        chk("rc_c3_req", imem_req, 32'h0);
        chk("rc_c3_vld", id_valid, 32'h0);
        adv();
        for (int k = 4; k < 10; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            if (k == 4) chk("rc_c4_req", imem_req, 32'h0);
            if (k == 5) begin
                chk("rc_c5_req",  imem_req, 32'h1);
                chk("rc_c5_addr", imem_address, 32'h200);
            end
            if (k == 9 - BYP) begin
                chk("rc_first_vld", id_valid, 32'h1);
                chk("rc_first_pc",  id_pc, 32'h200);
            end else if (k < 9 - BYP) begin
                chk($sformatf("rc_c%0d_vld", k), id_valid, 32'h0);
            end
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
